// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan decoder.
// Glyph bytes are active-low cathode patterns with the decimal point off.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_D = 8'hA1;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // Entry i holds the glyph for hex value i.
  localparam logic [15:0][7:0] GLYPH_TBL = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       unknown;
  } digit_rec_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Maps seven active-low segment lines (a..g) to a hex nibble; patterns that
// are not one of the sixteen glyphs report unknown with nibble 0.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_unknown
);

  always_comb begin
    o_nibble  = '0;
    o_unknown = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == GLYPH_TBL[i][6:0]) begin
        o_nibble  = 4'(i);
        o_unknown = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers 8 hex digits from a scanned, multiplexed 7-segment display bus.
// Optional blank-display timeout is enabled with `define SEG_SCAN_TIMEOUT_EN.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        i_oszClk,
  input  logic        i_nReset,
  input  logic [7:0]  i_anodes,
  input  logic [7:0]  i_cathodes,
  output logic [31:0] o_digits,
  output logic [7:0]  o_dp,
  output logic [7:0]  o_unknown,
  output logic        o_frameValid,
  output logic        o_blank
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [7:0]  an_s1_q, an_s2_q, ca_s1_q, ca_s2_q;
  logic [15:0] sample, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        active, accept, tmo_hit;
  logic [2:0]  idx;
  logic [3:0]  dec_nibble;
  logic        dec_unknown;

  digit_rec_t [NUM_DIGITS-1:0] store_q, store_d;
  logic [NUM_DIGITS-1:0]       seen_q, seen_d;
  logic [31:0]                 digits_q, digits_d;
  logic [7:0]                  dp_q, dp_d, unk_q, unk_d;
  logic                        fv_q, fv_d;

  // Synchronizers reset to all-ones so the bus looks idle out of reset.
  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      an_s1_q <= '1;
      an_s2_q <= '1;
      ca_s1_q <= '1;
      ca_s2_q <= '1;
    end else begin
      an_s1_q <= i_anodes;
      an_s2_q <= an_s1_q;
      ca_s1_q <= i_cathodes;
      ca_s2_q <= ca_s1_q;
    end
  end

  assign sample = {an_s2_q, ca_s2_q};

  seg_glyph_decode u_dec (
    .i_seg     (ca_s2_q[6:0]),
    .o_nibble  (dec_nibble),
    .o_unknown (dec_unknown)
  );

  always_comb begin
    active = $onehot(~an_s2_q);
    idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2_q[i]) idx = 3'(i);
    end
  end

  // Accept only on the transition into STABLE so a held pattern fires once.
  always_comb begin
    cnt_d = cnt_q;
    if (!active)                cnt_d = '0;
    else if (sample != prev_q)  cnt_d = 8'd1;
    else if (cnt_q < STABLE_C)  cnt_d = cnt_q + 8'd1;
    accept = active && (cnt_d == STABLE_C) && (cnt_q != STABLE_C);
  end

  always_comb begin
    store_d  = store_q;
    seen_d   = seen_q;
    digits_d = digits_q;
    dp_d     = dp_q;
    unk_d    = unk_q;
    fv_d     = 1'b0;
    if (accept) begin
      store_d[idx] = '{nibble: dec_nibble, dp: ~ca_s2_q[7], unknown: dec_unknown};
      seen_d[idx]  = 1'b1;
    end
    if (seen_d == '1) begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        digits_d[4*n +: 4] = store_d[n].nibble;
        dp_d[n]            = store_d[n].dp;
        unk_d[n]           = store_d[n].unknown;
      end
      fv_d   = 1'b1;
      seen_d = '0;
    end else if (tmo_hit) begin
      seen_d = '0;
    end
  end

  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      prev_q   <= '1;
      cnt_q    <= '0;
      store_q  <= '0;
      seen_q   <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      unk_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      unk_q    <= unk_d;
      fv_q     <= fv_d;
    end
  end

  assign o_digits     = digits_q;
  assign o_dp         = dp_q;
  assign o_unknown    = unk_q;
  assign o_frameValid = fv_q;

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);

  logic [15:0] idle_q, idle_d;
  logic        blank_q, blank_d;

  // Counter saturates at the limit so the blank event fires only once.
  always_comb begin
    idle_d  = idle_q;
    blank_d = blank_q;
    tmo_hit = 1'b0;
    if (accept) begin
      idle_d  = '0;
      blank_d = 1'b0;
    end else if (idle_q != TIMEOUT_C) begin
      idle_d = idle_q + 16'd1;
      if (idle_d == TIMEOUT_C) begin
        blank_d = 1'b1;
        tmo_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      idle_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      blank_q <= blank_d;
    end
  end

  assign o_blank = blank_q;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
  assign o_blank        = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-frame scans plus
// hand-written glitch, double-anode, reset and timeout sequences.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;

  typedef struct packed {
    logic [7:0][7:0] cath;
    logic            rev;
    logic [31:0]     exp_digits;
    logic [7:0]      exp_dp;
    logic [7:0]      exp_unk;
  } vec_t;

  logic        i_oszClk = 1'b0;
  logic        i_nReset;
  logic [7:0]  i_anodes;
  logic [7:0]  i_cathodes;
  logic [31:0] o_digits;
  logic [7:0]  o_dp, o_unknown;
  logic        o_frameValid, o_blank;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [31:0] cap_digits = '0;
  logic [7:0]  cap_dp = '0, cap_unk = '0;
  vec_t vecs [4];

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(100)) dut (
    .i_oszClk     (i_oszClk),
    .i_nReset     (i_nReset),
    .i_anodes     (i_anodes),
    .i_cathodes   (i_cathodes),
    .o_digits     (o_digits),
    .o_dp         (o_dp),
    .o_unknown    (o_unknown),
    .o_frameValid (o_frameValid),
    .o_blank      (o_blank)
  );

  always #5 i_oszClk = ~i_oszClk;

  always @(negedge i_oszClk) begin
    if (o_frameValid) begin
      frames     <= frames + 1;
      cap_digits <= o_digits;
      cap_dp     <= o_dp;
      cap_unk    <= o_unknown;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic show(input int d, input logic [7:0] c, input int n);
    logic [7:0] one;
    one        = 8'h01;
    i_anodes   = ~(one << d);
    i_cathodes = c;
    repeat (n) @(negedge i_oszClk);
  endtask

  task automatic idle(input int n);
    i_anodes   = 8'hFF;
    i_cathodes = 8'hFF;
    repeat (n) @(negedge i_oszClk);
  endtask

  task automatic scan(input vec_t v);
    int d;
    for (int k = 0; k < 8; k++) begin
      d = v.rev ? 7 - k : k;
      show(d, v.cath[d], 10);
    end
  endtask

  initial begin
    int f0;
    vecs[0] = '{cath: {8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0},
                rev: 1'b0, exp_digits: 32'hDCBA3210, exp_dp: 8'h00, exp_unk: 8'h00};
    vecs[1] = '{cath: {8'h90, 8'h80, 8'h8E, 8'h86, 8'hF8, 8'h00, 8'h92, 8'h99},
                rev: 1'b1, exp_digits: 32'h98FE7854, exp_dp: 8'h04, exp_unk: 8'h00};
    vecs[2] = '{cath: {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFE, 8'h79, 8'hC0},
                rev: 1'b0, exp_digits: 32'h00000010, exp_dp: 8'h02, exp_unk: 8'h04};
    vecs[3] = '{cath: {8'h78, 8'h02, 8'hFF, 8'h19, 8'h30, 8'h24, 8'h79, 8'h40},
                rev: 1'b0, exp_digits: 32'h76043210, exp_dp: 8'hDF, exp_unk: 8'h20};

    i_nReset   = 1'b0;
    i_anodes   = 8'hFF;
    i_cathodes = 8'hFF;
    repeat (3) @(negedge i_oszClk);
    chk("reset_digits", o_digits, 32'h0);
    chk("reset_dp_unk_fv_blank", {14'h0, o_dp, o_unknown, o_frameValid, o_blank}, 32'h0);
    i_nReset = 1'b1;
    idle(3);

    // Stale value on digit 1 must be overwritten by the later scan.
    show(1, 8'h86, 10);
    for (int v = 0; v < 4; v++) begin
      f0 = frames;
      scan(vecs[v]);
      idle(3);
      chk($sformatf("vec%0d_frames", v), 32'(frames - f0), 32'd1);
      chk($sformatf("vec%0d_digits", v), cap_digits, vecs[v].exp_digits);
      chk($sformatf("vec%0d_dp", v), {24'h0, cap_dp}, {24'h0, vecs[v].exp_dp});
      chk($sformatf("vec%0d_unk", v), {24'h0, cap_unk}, {24'h0, vecs[v].exp_unk});
      chk($sformatf("vec%0d_held", v), o_digits, vecs[v].exp_digits);
    end

    // Glitch on the last digit: a short wrong pattern must not complete the frame.
    f0 = frames;
    for (int d = 0; d < 7; d++) show(d, vecs[0].cath[d], 10);
    show(7, 8'h86, STABLE - 1);
    show(7, 8'hA1, 10);
    idle(3);
    chk("glitch_frames", 32'(frames - f0), 32'd1);
    chk("glitch_digits", cap_digits, 32'hDCBA3210);

    // Anodes 0 and 7 low together: must not mark either digit seen.
    f0 = frames;
    i_anodes   = 8'h7E;
    i_cathodes = 8'hC0;
    repeat (20) @(negedge i_oszClk);
    for (int d = 1; d < 7; d++) show(d, vecs[1].cath[d], 10);
    idle(3);
    chk("dual_no_frame_a", 32'(frames - f0), 32'd0);
    show(0, vecs[1].cath[0], 10);
    idle(3);
    chk("dual_no_frame_b", 32'(frames - f0), 32'd0);
    show(7, vecs[1].cath[7], 10);
    idle(3);
    chk("dual_frame", 32'(frames - f0), 32'd1);
    chk("dual_digits", cap_digits, 32'h98FE7854);

    // Reset after 5 digits discards them.
    f0 = frames;
    for (int d = 0; d < 5; d++) show(d, vecs[0].cath[d], 10);
    i_nReset = 1'b0;
    repeat (2) @(negedge i_oszClk);
    chk("midreset_digits", o_digits, 32'h0);
    chk("midreset_dp_unk", {16'h0, o_dp, o_unknown}, 32'h0);
    i_nReset = 1'b1;
    for (int d = 5; d < 8; d++) show(d, vecs[0].cath[d], 10);
    idle(3);
    chk("midreset_no_frame", 32'(frames - f0), 32'd0);
    chk("midreset_outputs_zero", o_digits, 32'h0);
    scan(vecs[0]);
    idle(3);
    chk("midreset_frame", 32'(frames - f0), 32'd1);
    chk("midreset_digits_after", o_digits, 32'hDCBA3210);

`ifdef SEG_SCAN_TIMEOUT_EN
    f0 = frames;
    for (int d = 0; d < 4; d++) show(d, vecs[1].cath[d], 10);
    idle(80);
    chk("tmo_not_yet", {31'h0, o_blank}, 32'd0);
    idle(40);
    chk("tmo_blank", {31'h0, o_blank}, 32'd1);
    show(4, vecs[1].cath[4], 10);
    chk("tmo_cleared", {31'h0, o_blank}, 32'd0);
    for (int d = 5; d < 8; d++) show(d, vecs[1].cath[d], 10);
    idle(3);
    chk("tmo_mask_cleared", 32'(frames - f0), 32'd0);
    for (int d = 0; d < 4; d++) show(d, vecs[1].cath[d], 10);
    idle(3);
    chk("tmo_frame", 32'(frames - f0), 32'd1);
    chk("tmo_digits", cap_digits, 32'h98FE7854);
`else
    idle(120);
    chk("blank_tied_low", {31'h0, o_blank}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
